// File: rtl/mapa_arbiter.sv
// Three-way arbiter for the 2-bit map RAM: (x, y) -> linear address, starvation-bounded
// priority for the renderer, and a per-requester lock for read-modify-write. Optional ARB_STATS_EN.
module mapa_arbiter #(
    parameter int MAPA_WIDTH   = 40,
    parameter int MAPA_HEIGHT  = 30,
    parameter int ADDR_W       = 11,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        req,
    input  logic [2:0]        lock,
    input  logic [2:0]        we,
    input  logic [29:0]       rx_flat,
    input  logic [29:0]       ry_flat,
    input  logic [5:0]        wdata_flat,
    output logic [2:0]        gnt,
    output logic [2:0]        rvalid,
    output logic [1:0]        rdata,
    output logic              addr_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [1:0]        mem_wdata,
    input  logic [1:0]        mem_rdata
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]       stat_conflicts,
    output logic [7:0]        stat_starve
`endif
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [9:0]        W_LIM = 10'(MAPA_WIDTH);
    localparam logic [9:0]        H_LIM = 10'(MAPA_HEIGHT);
    localparam logic [ADDR_W-1:0] ROW   = ADDR_W'(MAPA_WIDTH);
    localparam logic [SW-1:0]     S_LIM = SW'(STARVE_LIMIT);

    typedef enum logic {ARB, LOCKED} state_t;

    state_t            state_q, state_d;
    logic [2:0]        owner_q, owner_d;
    logic              idle_q;
    logic              rr_q;
    logic [SW-1:0]     starve_q;

    logic              lo_pend, starve_hit, owner_req, any_win;
    logic [2:0]        win;
    logic [9:0]        x_sel, y_sel;
    logic              we_sel, lock_sel, oor;
    logic [1:0]        wd_sel;
    logic [ADDR_W-1:0] lin_addr;

    logic [2:0]        rd_pend_q;
    logic              rd_oor_q, rv_oor_q;
    logic [1:0]        rdata_q;

    // Winner selection: a lock owner excludes everyone else, otherwise the renderer
    // wins unless it has starved the other two for STARVE_LIMIT grants in a row.
    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        lo_pend    = req[0] | req[1];
        starve_hit = (starve_q == S_LIM) && lo_pend;
        owner_req  = |(req & owner_q);
        win        = '0;
        if (state_q == LOCKED)
            win = req & owner_q;
        else if (req[2] && !starve_hit)
            win = 3'b100;
        else if (req[0] && req[1])
            win = rr_q ? 3'b010 : 3'b001;
        else if (req[0])
            win = 3'b001;
        else if (req[1])
            win = 3'b010;
        any_win = |win;
    end

    always_comb begin
        x_sel    = rx_flat[29:20];
        y_sel    = ry_flat[29:20];
        wd_sel   = wdata_flat[5:4];
        we_sel   = we[2];
        lock_sel = lock[2];
        if (win[0]) begin
            x_sel = rx_flat[9:0];   y_sel = ry_flat[9:0];   wd_sel = wdata_flat[1:0];
            we_sel = we[0];         lock_sel = lock[0];
        end else if (win[1]) begin
            x_sel = rx_flat[19:10]; y_sel = ry_flat[19:10]; wd_sel = wdata_flat[3:2];
            we_sel = we[1];         lock_sel = lock[1];
        end
        oor      = (x_sel >= W_LIM) || (y_sel >= H_LIM);
        lin_addr = ADDR_W'(y_sel) * ROW + ADDR_W'(x_sel);
    end

    // A lock is released by an unlocked access of the owner or two idle owner cycles.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        if (any_win && lock_sel) begin
            state_d = LOCKED;
            owner_d = win;
        end else if (state_q == LOCKED && (any_win || (!owner_req && idle_q))) begin
            state_d = ARB;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ARB;
            owner_q   <= '0;
            idle_q    <= 1'b0;
            rr_q      <= 1'b0;
            starve_q  <= '0;
            gnt       <= '0;
            addr_err  <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rd_pend_q <= '0;
            rd_oor_q  <= 1'b0;
            rvalid    <= '0;
            rv_oor_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            idle_q  <= (state_q == LOCKED) && !owner_req;
            if (win[0])
                rr_q <= 1'b1;
            else if (win[1])
                rr_q <= 1'b0;
            if (state_q == ARB) begin
                if (!lo_pend || win[0] || win[1])
                    starve_q <= '0;
                else if (win[2])
                    starve_q <= starve_q + SW'(1);
            end
            gnt      <= win;
            addr_err <= any_win && oor;
            mem_en   <= any_win && !oor;
            mem_we   <= any_win && !oor && we_sel;
            if (any_win && !oor) begin
                mem_addr  <= lin_addr;
                mem_wdata <= wd_sel;
            end
            rd_pend_q <= (any_win && !we_sel) ? win : 3'b000;
            rd_oor_q  <= oor;
            rvalid    <= rd_pend_q;
            rv_oor_q  <= rd_oor_q;
            rdata_q   <= rdata;
        end
    end

    // Read data comes straight from the RAM in the response cycle and is held afterwards.
    always_comb begin
        rdata = rdata_q;
        if (|rvalid)
            rdata = rv_oor_q ? 2'b11 : mem_rdata;
    end

`ifdef ARB_STATS_EN
    logic conflict, override;

    assign conflict = (req[0] & req[1]) | (req[0] & req[2]) | (req[1] & req[2]);
    assign override = (state_q == ARB) && req[2] && starve_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_conflicts <= '0;
            stat_starve    <= '0;
        end else begin
            if (conflict && stat_conflicts != '1)
                stat_conflicts <= stat_conflicts + 16'd1;
            if (override && stat_starve != '1)
                stat_starve <= stat_starve + 8'd1;
        end
    end
`endif

endmodule

// File: doc/mapa_arbiter.md
Name: mapa_arbiter

Overview:
- Shares the single-port map RAM (2-bit cells: 00 empty, 01 snake, 10 fruit, 11 obstacle) between three requesters.
- Requesters: 0 = game update engine, 1 = fruit/obstacle placer, 2 = VGA renderer.
- Converts (x, y) to a linear address, issues one access per cycle, and returns read data with a fixed latency.
- Supports a lock so a requester can do an atomic read-modify-write, e.g. "place fruit only if the cell is empty".

Parameters:
- MAPA_WIDTH, 40, cells per row.
- MAPA_HEIGHT, 30, rows.
- ADDR_W, 11, memory address width; must satisfy MAPA_WIDTH*MAPA_HEIGHT <= 2^ADDR_W.
- STARVE_LIMIT, 4, maximum consecutive requester-2 grants while requester 0 or 1 is pending.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req  in  3  per-requester access request; held high until gnt.
- lock  in  3  per-requester lock; sampled with the granted access.
- we  in  3  per-requester write enable (1 = write).
- rx_flat  in  30  per-requester x coordinate, 10 bits each, requester i at [10i+9:10i].
- ry_flat  in  30  per-requester y coordinate, 10 bits each.
- wdata_flat  in  6  per-requester write data, 2 bits each.
- gnt  out  3  one-hot, one-cycle grant pulse.
- rvalid  out  3  one-hot, one-cycle read-data-valid pulse.
- rdata  out  2  read data; valid when any rvalid bit is high.
- addr_err  out  1  one-cycle pulse on an out-of-range access.
- mem_en  out  1  memory enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  linear address = y*MAPA_WIDTH + x.
- mem_wdata  out  2  memory write data.
- mem_rdata  in  2  memory read data; valid one cycle after mem_en with mem_we=0.

Behaviour:
- Reset values: gnt=0, rvalid=0, rdata=0, addr_err=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - State returns to ARB, round-robin pointer to 0, starvation counter to 0.
  - Any in-flight read is discarded and no rvalid is produced.
- Timing:
  - Cycle t: arbiter samples req.
  - Cycle t+1: registered gnt[i] and mem_* outputs for the winner.
  - Cycle t+2 (reads only): rvalid[i] and rdata = mem_rdata.
  - Back-to-back grants are allowed; throughput is one access per cycle.
  - A requester deasserts req, or presents its next access, in the cycle after it sees gnt.
  - A requester whose req is still high in the gnt cycle is treated as a new request, so a held req yields at most one access every 2 cycles for that requester.
- State ARB, selection:
  - Requester 2 has priority unless the starvation counter equals STARVE_LIMIT and req[0] or req[1] is high.
  - Requesters 0 and 1 share by round-robin; the pointer advances past the winner.
  - Starvation counter: increments on each requester-2 grant while req[0] or req[1] is high; clears on any requester-0 or requester-1 grant, or when both are idle.
- Lock:
  - A granted access with lock[i]=1 moves the block to LOCKED(i).
  - LOCKED(i): only requester i can win. Starvation logic is suspended.
  - The next granted access of i with lock[i]=0 returns the block to ARB after that access.
  - req[i]=0 for 2 consecutive cycles also returns the block to ARB.
- Out of range (x >= MAPA_WIDTH or y >= MAPA_HEIGHT):
  - gnt is still issued; mem_en stays 0; addr_err pulses with gnt.
  - Writes are dropped.
  - Reads return rvalid at the normal latency with rdata=2'b11 (treated as an obstacle).
- Address arithmetic: computed at ADDR_W bits, unsigned, no wrap.
- Simultaneous events: a read response and a new grant may occur in the same cycle. When no read is returning, rvalid=0 and rdata holds its last value.

Optional Feature:
- ARB_STATS_EN:
  - When defined, adds outputs stat_conflicts (16 bits), incremented on every cycle where more than one req bit is high, and stat_starve (8 bits), incremented on every starvation override.
  - Both counters saturate and clear on reset.
  - When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Single read, requester 0, x=10, y=10:
  - gnt[0] at t+1 with mem_addr=410 and mem_we=0.
  - rvalid[0] at t+2 with rdata equal to the preloaded 2'b01.
- req[0] and req[1] held continuously, each issuing writes: grants alternate 0,1,0,1; no requester receives two consecutive grants.
- req=3'b111 held, requester 2 continuous:
  - Requester 2 receives exactly 4 consecutive grants.
  - Then requester 0 or 1 receives 1 grant; the pattern repeats.
- Requester 1 locked read at (5,7) returning 00, then unlocked write of 10:
  - req[0] held throughout receives no grant until after the write.
  - Memory cell 285 = 10.
- Requester 0 reads (40,3): gnt[0] and addr_err pulse together, mem_en=0, and rvalid[0] at t+2 with rdata=11.
- Reset asserted in the cycle after a read gnt: no rvalid follows, all outputs are 0, and the next grant goes to requester 0 under round-robin.
